cdb_arbiter: RTL and testbench

//   Transmit side of the Common Data Bus (CDB). Collects completed results

---
 rtl/cdb_arbiter.sv | 85 ++++++++
 tb/tb_cdb_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus transmit arbiter: round-robin pick of one completed result
// per cycle from NUM_SRC execution units, broadcast through a one-cycle register.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        Src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  Src_rd_tag,
    input  logic [NUM_SRC*DATA_W-1:0] Src_data,
    input  logic [NUM_SRC-1:0]        Src_branch,
    input  logic [NUM_SRC-1:0]        Src_branch_taken,
    output logic [NUM_SRC-1:0]        Src_grant,
    output logic                      Cdb_valid,
    output logic [TAG_W-1:0]          Cdb_rd_tag,
    output logic [DATA_W-1:0]         Cdb_data,
    output logic                      Cdb_branch,
    output logic                      Cdb_branch_taken
);

    localparam int IDX_W = $clog2(NUM_SRC);

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  grant_idx;
    logic              found;
    logic [NUM_SRC-1:0] grant;

    logic              vld_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [DATA_W-1:0] data_p1;
    logic              branch_p1;
    logic              taken_p1;

    // Stage p0: search starts just past the last winner so it drops to lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!found && Src_valid[cand] && !flush && !reset) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign Src_grant = grant;

    // Stage p1: broadcast register; payload holds when nothing wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= IDX_W'(NUM_SRC - 1);
            vld_p1    <= 1'b0;
            tag_p1    <= '0;
            data_p1   <= '0;
            branch_p1 <= 1'b0;
            taken_p1  <= 1'b0;
        end else begin
            vld_p1 <= found;
            if (found) begin
                rr_ptr    <= grant_idx;
                tag_p1    <= Src_rd_tag[grant_idx*TAG_W +: TAG_W];
                data_p1   <= Src_data[grant_idx*DATA_W +: DATA_W];
                branch_p1 <= Src_branch[grant_idx];
                taken_p1  <= Src_branch_taken[grant_idx];
            end
        end
    end

    assign Cdb_valid        = vld_p1;
    assign Cdb_rd_tag       = tag_p1;
    assign Cdb_data         = data_p1;
    assign Cdb_branch       = branch_p1;
    assign Cdb_branch_taken = taken_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Vector-table bench for cdb_arbiter: per-cycle grant checks plus a scoreboard
// of expected bus broadcasts, followed by hand-written reset sequences.
module tb_cdb_arbiter;

    logic         clock;
    logic         reset;
    logic         flush;
    logic [3:0]   Src_valid;
    logic [19:0]  Src_rd_tag;
    logic [127:0] Src_data;
    logic [3:0]   Src_branch;
    logic [3:0]   Src_branch_taken;
    logic [3:0]   Src_grant;
    logic         Cdb_valid;
    logic [4:0]   Cdb_rd_tag;
    logic [31:0]  Cdb_data;
    logic         Cdb_branch;
    logic         Cdb_branch_taken;

    cdb_arbiter #(.NUM_SRC(4), .TAG_W(5), .DATA_W(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .Src_valid        (Src_valid),
        .Src_rd_tag       (Src_rd_tag),
        .Src_data         (Src_data),
        .Src_branch       (Src_branch),
        .Src_branch_taken (Src_branch_taken),
        .Src_grant        (Src_grant),
        .Cdb_valid        (Cdb_valid),
        .Cdb_rd_tag       (Cdb_rd_tag),
        .Cdb_data         (Cdb_data),
        .Cdb_branch       (Cdb_branch),
        .Cdb_branch_taken (Cdb_branch_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]   valid;
        logic         flush;
        logic [19:0]  tags;
        logic [127:0] data;
        logic [3:0]   br;
        logic [3:0]   tk;
        logic [3:0]   exp_grant;
    } vec_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  tag;
        logic [31:0] data;
        logic        br;
        logic        tk;
    } bus_t;

    vec_t vecs[$];
    bus_t sb[$];
    bus_t exp_hold;
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic f, input logic [3:0] g);
        vec_t e;
        e.valid = v;
        e.flush = f;
        e.br    = '0;
        e.tk    = '0;
        e.exp_grant = g;
        for (int i = 0; i < 4; i++) begin
            e.tags[i*5 +: 5]  = 5'(i);
            e.data[i*32 +: 32] = 32'hC0DE_0000 | (32'(vecs.size()) << 4) | 32'(i);
        end
        return e;
    endfunction

    function automatic bus_t bus_now();
        bus_t b;
        b.v    = Cdb_valid;
        b.tag  = Cdb_rd_tag;
        b.data = Cdb_data;
        b.br   = Cdb_branch;
        b.tk   = Cdb_branch_taken;
        return b;
    endfunction

    // Called one time unit after a rising edge; returns at the same phase one cycle later.
    task automatic run_vec(input vec_t e, input int n);
        bus_t exp_b;
        bus_t got;
        Src_valid        = e.valid;
        flush            = e.flush;
        Src_rd_tag       = e.tags;
        Src_data         = e.data;
        Src_branch       = e.br;
        Src_branch_taken = e.tk;
        #4;
        chk($sformatf("grant[%0d]", n), 64'(Src_grant), 64'(e.exp_grant));
        exp_b = exp_hold;
        exp_b.v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (e.exp_grant == 4'(1 << i)) begin
                exp_b.v    = 1'b1;
                exp_b.tag  = e.tags[i*5 +: 5];
                exp_b.data = e.data[i*32 +: 32];
                exp_b.br   = e.br[i];
                exp_b.tk   = e.tk[i];
            end
        end
        exp_hold = exp_b;
        sb.push_back(exp_b);
        @(posedge clock);
        #1;
        got = bus_now();
        if (sb.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", n), 64'd1, 64'd0);
        end else begin
            chk($sformatf("cdb[%0d]", n), 64'(got), 64'(sb.pop_front()));
        end
    endtask

    initial begin
        vec_t e;
        n_checks = 0;
        n_fail   = 0;
        exp_hold = '0;

        // Round robin from reset: 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) vecs.push_back(mk(4'b1111, 1'b0, 4'(1 << (i % 4))));
        // Single source unit 2, then idle (payload must hold)
        e = mk(4'b0100, 1'b0, 4'b0100);
        e.tags[10 +: 5]  = 5'd7;
        e.data[64 +: 32] = 32'hDEAD_BEEF;
        vecs.push_back(e);
        vecs.push_back(mk(4'b0000, 1'b0, 4'b0000));
        // Fairness: units 0 and 3, unit 3 first
        vecs.push_back(mk(4'b1001, 1'b0, 4'b1000));
        vecs.push_back(mk(4'b1001, 1'b0, 4'b0001));
        vecs.push_back(mk(4'b1001, 1'b0, 4'b1000));
        vecs.push_back(mk(4'b1001, 1'b0, 4'b0001));
        // Flush with units 1,2 pending; unit 1 wins afterwards
        vecs.push_back(mk(4'b0110, 1'b1, 4'b0000));
        vecs.push_back(mk(4'b0110, 1'b0, 4'b0010));
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0100));
        // Taken branch on unit 1, wrapping search from unit 3
        e = mk(4'b0010, 1'b0, 4'b0010);
        e.tags[5 +: 5] = 5'd31;
        e.br = 4'b0010;
        e.tk = 4'b0010;
        vecs.push_back(e);

        reset = 1'b1;
        flush = 1'b0;
        Src_valid = 4'b1111;
        Src_rd_tag = '1;
        Src_data = '1;
        Src_branch = '1;
        Src_branch_taken = '1;
        #10;
        chk("rst_grant", 64'(Src_grant), 64'd0);
        chk("rst_bus", 64'(bus_now()), 64'd0);
        @(posedge clock);
        #1;
        chk("rst_grant2", 64'(Src_grant), 64'd0);
        chk("rst_bus2", 64'(bus_now()), 64'd0);
        reset = 1'b0;
        Src_valid = 4'b0000;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        chk("branch_on_bus", 64'({Cdb_valid, Cdb_branch, Cdb_branch_taken, Cdb_rd_tag}), 64'({3'b111, 5'd31}));

        // Asynchronous reset mid-cycle while a broadcast is on the bus
        Src_valid = 4'b1111;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_bus", 64'(bus_now()), 64'd0);
        chk("async_rst_grant", 64'(Src_grant), 64'd0);
        #1;
        reset = 1'b0;
        Src_valid = 4'b0000;
        @(posedge clock);
        #1;
        chk("post_rst_idle", 64'(Cdb_valid), 64'd0);
        sb.delete();
        exp_hold = '0;
        run_vec(mk(4'b1111, 1'b0, 4'b0001), 100);
        run_vec(mk(4'b1010, 1'b0, 4'b0010), 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
